// File: rtl/uart_hex_parser_pkg.sv
// Shared definitions for the UART hex parser: FSM states, ASCII constants, error codes.
package uart_hex_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    DISCARD = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_INVALID  = 2'b01,
    ERR_OVERFLOW = 2'b10
  } err_t;

  localparam logic [7:0] ASC_CR   = 8'h0D;
  localparam logic [7:0] ASC_LF   = 8'h0A;
  localparam logic [7:0] ASC_SP   = 8'h20;
  localparam logic [7:0] ASC_0    = 8'h30;
  localparam logic [7:0] ASC_9    = 8'h39;
  localparam logic [7:0] ASC_A_UC = 8'h41;
  localparam logic [7:0] ASC_F_UC = 8'h46;
  localparam logic [7:0] ASC_A_LC = 8'h61;
  localparam logic [7:0] ASC_F_LC = 8'h66;
endpackage

// File: rtl/uart_hex_parser_if.sv
// Byte stream in, parsed word / error strobes out.
interface uart_hex_parser_if #(parameter int DATA_W = 32);
  logic              i_Rx_DV;
  logic [7:0]        i_Rx_Byte;
  logic              o_Word_DV;
  logic [DATA_W-1:0] o_Word;
  logic [6:0]        o_Digit_Cnt;
  logic              o_Err;
  logic [1:0]        o_Err_Code;

  modport master (
    output i_Rx_DV, i_Rx_Byte,
    input  o_Word_DV, o_Word, o_Digit_Cnt, o_Err, o_Err_Code
  );
  modport slave (
    input  i_Rx_DV, i_Rx_Byte,
    output o_Word_DV, o_Word, o_Digit_Cnt, o_Err, o_Err_Code
  );
endinterface

// File: rtl/hex_ascii_decode.sv
// Combinational ASCII classifier: hex digit (case-insensitive) with nibble, or terminator.
module hex_ascii_decode
  import uart_hex_pkg::*;
(
  input  logic [7:0] i_Byte,
  output logic       o_Is_Digit,
  output logic       o_Is_Term,
  output logic [3:0] o_Nibble
);
  always_comb begin
    o_Is_Digit = 1'b0;
    o_Nibble   = 4'h0;
    if (i_Byte >= ASC_0 && i_Byte <= ASC_9) begin
      o_Is_Digit = 1'b1;
      o_Nibble   = 4'(i_Byte - ASC_0);
    end else if (i_Byte >= ASC_A_UC && i_Byte <= ASC_F_UC) begin
      o_Is_Digit = 1'b1;
      o_Nibble   = 4'(i_Byte - ASC_A_UC + 8'd10);
    end else if (i_Byte >= ASC_A_LC && i_Byte <= ASC_F_LC) begin
      o_Is_Digit = 1'b1;
      o_Nibble   = 4'(i_Byte - ASC_A_LC + 8'd10);
    end
  end

  assign o_Is_Term = (i_Byte == ASC_CR) || (i_Byte == ASC_LF) || (i_Byte == ASC_SP);
endmodule

// File: rtl/uart_hex_parser.sv
// Parses ASCII hex tokens from the UART byte stream into DATA_W-bit words.
module uart_hex_parser
  import uart_hex_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int MAX_DIGITS = DATA_W / 4
) (
  input  logic i_Clock,
  input  logic i_Reset_n,
  uart_hex_parser_if.slave bus
);
  logic       w_is_digit, w_is_term;
  logic [3:0] w_nibble;

  hex_ascii_decode u_dec (
    .i_Byte     (bus.i_Rx_Byte),
    .o_Is_Digit (w_is_digit),
    .o_Is_Term  (w_is_term),
    .o_Nibble   (w_nibble)
  );

  state_t            r_state, w_state_nx;
  logic [DATA_W-1:0] r_acc, w_acc_nx;
  logic [DATA_W-1:0] r_word, w_word_nx;
  logic [6:0]        r_cnt, w_cnt_nx;
  logic              r_word_dv, w_word_dv_nx;
  logic              r_err, w_err_nx;
  err_t              r_err_code, w_err_code_nx;

  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      r_state    <= IDLE;
      r_acc      <= '0;
      r_word     <= '0;
      r_cnt      <= '0;
      r_word_dv  <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
    end else begin
      r_state    <= w_state_nx;
      r_acc      <= w_acc_nx;
      r_word     <= w_word_nx;
      r_cnt      <= w_cnt_nx;
      r_word_dv  <= w_word_dv_nx;
      r_err      <= w_err_nx;
      r_err_code <= w_err_code_nx;
    end
  end

  always_comb begin
    w_state_nx    = r_state;
    w_acc_nx      = r_acc;
    w_word_nx     = r_word;
    w_cnt_nx      = r_cnt;
    w_word_dv_nx  = 1'b0;
    w_err_nx      = 1'b0;
    w_err_code_nx = r_err_code;
    case (r_state)
      IDLE: begin
        // Terminators in IDLE are swallowed so CR LF pairs emit a single word.
        if (bus.i_Rx_DV) begin
          if (w_is_digit) begin
            w_acc_nx   = DATA_W'(w_nibble);
            w_cnt_nx   = 7'd1;
            w_state_nx = ACCUM;
          end else if (!w_is_term) begin
            w_err_nx      = 1'b1;
            w_err_code_nx = ERR_INVALID;
            w_state_nx    = DISCARD;
          end
        end
      end
      ACCUM: begin
        if (bus.i_Rx_DV) begin
          if (w_is_digit) begin
            if (r_cnt < 7'(MAX_DIGITS)) begin
              w_acc_nx = (r_acc << 4) | DATA_W'(w_nibble);
              w_cnt_nx = r_cnt + 7'd1;
            end else begin
              w_err_nx      = 1'b1;
              w_err_code_nx = ERR_OVERFLOW;
              w_state_nx    = DISCARD;
            end
          end else if (w_is_term) begin
            w_word_nx    = r_acc;
            w_word_dv_nx = 1'b1;
            w_state_nx   = IDLE;
          end else begin
            w_err_nx      = 1'b1;
            w_err_code_nx = ERR_INVALID;
            w_state_nx    = DISCARD;
          end
        end
      end
      DISCARD: begin
        if (bus.i_Rx_DV && w_is_term) begin
          w_cnt_nx   = '0;
          w_state_nx = IDLE;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  assign bus.o_Word_DV   = r_word_dv;
  assign bus.o_Word      = r_word;
  assign bus.o_Digit_Cnt = r_cnt;
  assign bus.o_Err       = r_err;
  assign bus.o_Err_Code  = r_err_code;
endmodule
